// File: rtl/core_timer.sv
// rtl/core_timer.sv - memory-mapped mtime/mtimecmp machine timer with prescaler and level interrupt
module core_timer #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned RESET_DIV  = 0,
  parameter bit          RESET_EN   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [63:0]           req_wdata_i,
  input  logic [7:0]            req_be_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [63:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic [63:0]           time_o,
  output logic                  time_irq_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MTIME    = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MTIMECMP = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL     = ADDR_WIDTH'(8'h10);

  logic [63:0]          mtime_q, mtime_d;
  logic [63:0]          mtimecmp_q, mtimecmp_d;
  logic                 en_q, en_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [63:0]          resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;
  logic                 irq_q, irq_d;

  logic                 accept;
  logic                 tick;
  logic                 hit_mtime, hit_cmp, hit_ctrl, addr_ok;
  logic [63:0]          ctrl_rd;

  // Byte-lane merge of write data into an existing 64-bit register value.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  be);
    logic [63:0] res;
    res = old_val;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  // Address decode, handshake qualification, prescaler tick and CTRL read image.
  always_comb begin
    hit_mtime = (req_addr_i == ADDR_MTIME);
    hit_cmp   = (req_addr_i == ADDR_MTIMECMP);
    hit_ctrl  = (req_addr_i == ADDR_CTRL);
    addr_ok   = hit_mtime | hit_cmp | hit_ctrl;
    accept    = req_valid_i && !resp_valid_q;
    tick      = en_q && (cnt_q >= div_q);
    ctrl_rd   = '0;
    ctrl_rd[8 +: DIV_WIDTH] = div_q;
    ctrl_rd[0] = en_q;
  end

  // Next-state: prescaler, mtime, interrupt compare, register writes and response capture.
  always_comb begin
    mtime_d      = mtime_q;
    mtimecmp_d   = mtimecmp_q;
    en_d         = en_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    irq_d        = (mtime_q >= mtimecmp_q);

    if (en_q) begin
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
    end
    if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (resp_valid_q && resp_ready_i) begin
      resp_valid_d = 1'b0;
    end

    if (accept) begin
      resp_valid_d = 1'b1;
      resp_err_d   = !addr_ok;
      resp_rdata_d = '0;
      if (!req_we_i && addr_ok) begin
        if (hit_mtime)    resp_rdata_d = mtime_q;
        else if (hit_cmp) resp_rdata_d = mtimecmp_q;
        else              resp_rdata_d = ctrl_rd;
      end
      if (req_we_i && addr_ok) begin
        // A software write to MTIME overrides the increment from a coincident tick.
        if (hit_mtime) mtime_d = merge_bytes(mtime_q, req_wdata_i, req_be_i);
        if (hit_cmp)   mtimecmp_d = merge_bytes(mtimecmp_q, req_wdata_i, req_be_i);
        if (hit_ctrl) begin
          if (req_be_i[0]) en_d = req_wdata_i[0];
          for (int j = 0; j < DIV_WIDTH; j++) begin
            if (req_be_i[(8 + j) / 8]) div_d[j] = req_wdata_i[8 + j];
          end
        end
      end
    end
  end

  // State registers with synchronous reset; a reset drops any pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q      <= '0;
      mtimecmp_q   <= '1;
      en_q         <= RESET_EN;
      div_q        <= DIV_WIDTH'(RESET_DIV);
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      en_q         <= en_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      irq_q        <= irq_d;
    end
  end

  assign req_ready_o  = !resp_valid_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign time_o       = mtime_q;
  assign time_irq_o   = irq_q;

endmodule

// File: tb/tb_core_timer.sv
// tb/tb_core_timer.sv - scoreboard bench for core_timer against a behavioural timer model
module tb_core_timer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [11:0] req_addr_i = '0;
  logic [63:0] req_wdata_i = '0;
  logic [7:0]  req_be_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;
  logic [63:0] resp_rdata_o;
  logic        resp_err_o;
  logic [63:0] time_o;
  logic        time_irq_o;

  always #5 clk_i = ~clk_i;

  core_timer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .time_o(time_o), .time_irq_o(time_irq_o)
  );

  int unsigned n_vec = 0;
  int unsigned n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: timer state as plain integers, responses as a queue.
  typedef struct {
    logic [63:0] rdata;
    bit          err;
  } resp_t;
  resp_t       sb[$];
  logic [63:0] m_mtime, m_cmp;
  bit          m_en, m_irq, m_pending;
  int unsigned m_div, m_cnt;
  bit          checking = 1'b0;
  int          rdy_mode = 0;
  logic [63:0] last_rdata = '0;

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] w, input logic [7:0] be);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  // Model update at each clock edge, from the inputs the DUT sees at that edge.
  always @(posedge clk_i) begin : model
    logic [63:0] old_mtime, old_cmp, ctrl, rd;
    bit          tk, err;
    resp_t       r;
    if (rst_i) begin
      m_mtime = 0; m_cmp = '1; m_en = 1; m_div = 0; m_cnt = 0;
      m_irq = 0; m_pending = 0; sb.delete();
    end else begin
      old_mtime = m_mtime;
      old_cmp   = m_cmp;
      tk = m_en && (m_cnt >= m_div);
      if (m_en) m_cnt = tk ? 0 : m_cnt + 1;
      m_irq = (old_mtime >= old_cmp);
      if (tk) m_mtime = old_mtime + 64'd1;
      if (m_pending && resp_ready_i) begin
        m_pending = 0;
      end else if (req_valid_i && !m_pending) begin
        ctrl = (64'(m_div) << 8) | 64'(m_en);
        err = 1; rd = 0;
        case (req_addr_i)
          12'h000: begin
            err = 0; rd = old_mtime;
            if (req_we_i) m_mtime = merge(old_mtime, req_wdata_i, req_be_i);
          end
          12'h008: begin
            err = 0; rd = old_cmp;
            if (req_we_i) m_cmp = merge(old_cmp, req_wdata_i, req_be_i);
          end
          12'h010: begin
            err = 0; rd = ctrl;
            if (req_we_i) begin
              ctrl  = merge(ctrl, req_wdata_i, req_be_i);
              m_en  = ctrl[0];
              m_div = 32'(ctrl[23:8]);
            end
          end
          default: ;
        endcase
        if (req_we_i || err) rd = 0;
        r.rdata = rd;
        r.err   = err;
        sb.push_back(r);
        m_pending = 1;
      end
    end
  end

  // Monitor on the falling edge: outputs against model, responses against scoreboard head.
  always @(negedge clk_i) begin
    if (checking) begin
      chk("req_ready", 64'(req_ready_o), 64'(!m_pending));
      chk("resp_valid", 64'(resp_valid_o), 64'(m_pending));
      chk("time", time_o, m_mtime);
      chk("irq", 64'(time_irq_o), 64'(m_irq));
      if (resp_valid_o) begin
        if (sb.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL resp_unexpected actual=valid required=none at %0t", $time);
        end else begin
          chk("resp_rdata", resp_rdata_o, sb[0].rdata);
          chk("resp_err", 64'(resp_err_o), 64'(sb[0].err));
          if (resp_ready_i) begin
            last_rdata = resp_rdata_o;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  // Response-ready driver: always ready, random backpressure, or held low.
  always @(posedge clk_i) begin
    #1;
    case (rdy_mode)
      0:       resp_ready_i = 1'b1;
      1:       resp_ready_i = ($urandom % 3) != 0;
      default: resp_ready_i = 1'b0;
    endcase
  end

  task automatic do_req(input bit we, input logic [11:0] a, input logic [63:0] d, input logic [7:0] be);
    bit done;
    done = 0;
    @(posedge clk_i); #1;
    req_valid_i = 1; req_we_i = we; req_addr_i = a; req_wdata_i = d; req_be_i = be;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        @(posedge clk_i); #1;
        done = 1;
      end
    end
    req_valid_i = 0;
    if (!done) begin
      n_vec++; n_miss++;
      $display("FAIL req_timeout actual=not_accepted required=accepted addr=%h", a);
    end
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_i);
      if (sb.size() == 0 && !m_pending) done = 1;
    end
    if (!done) begin
      n_vec++; n_miss++;
      $display("FAIL drain_timeout actual=pending required=idle");
    end
  endtask

  initial begin
    logic [11:0] a;
    logic [63:0] d;
    rst_i = 1;
    repeat (3) @(posedge clk_i);
    #1;
    checking = 1;
    rst_i = 0;

    // Reset value of MTIMECMP.
    do_req(0, 12'h008, 0, 0);
    drain();
    chk("cmp_reset", last_rdata, 64'hFFFF_FFFF_FFFF_FFFF);

    // DIV=3: 40 cycles give 10 ticks.
    do_req(1, 12'h010, 64'h301, 8'hFF);
    do_req(1, 12'h000, 0, 8'hFF);
    repeat (40) @(posedge clk_i);
    #1;
    n_vec++;
    if (time_o < 64'd9 || time_o > 64'd11) begin
      n_miss++;
      $display("FAIL div3_rate actual=%0d required=10+-1", time_o);
    end

    // EN=0 freezes mtime.
    do_req(1, 12'h010, 64'h300, 8'hFF);
    repeat (20) @(posedge clk_i);

    // Compare interrupt rise and fall.
    do_req(1, 12'h008, 64'd5, 8'hFF);
    do_req(1, 12'h010, 64'h1, 8'hFF);
    do_req(1, 12'h000, 0, 8'hFF);
    repeat (15) @(posedge clk_i);
    do_req(1, 12'h008, 64'd100, 8'hFF);
    repeat (5) @(posedge clk_i);

    // mtime wrap.
    do_req(1, 12'h000, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    repeat (6) @(posedge clk_i);

    // Decode errors, be=0 no-op, partial byte write.
    do_req(0, 12'h018, 0, 0);
    do_req(0, 12'h004, 0, 0);
    do_req(1, 12'h018, 64'h1234, 8'hFF);
    do_req(1, 12'h000, 64'h1234, 8'h00);
    do_req(1, 12'h008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    do_req(1, 12'h008, 64'h1122_3344_5566_7788, 8'h0F);
    do_req(0, 12'h008, 0, 0);
    drain();
    chk("be_merge", last_rdata, 64'hFFFF_FFFF_5566_7788);

    // Backpressure then reset while the response is held and a second request waits.
    rdy_mode = 2;
    do_req(0, 12'h010, 0, 0);
    @(posedge clk_i); #1;
    req_valid_i = 1; req_we_i = 0; req_addr_i = 12'h008;
    repeat (5) @(posedge clk_i);
    #1;
    chk("stall_ready", 64'(req_ready_o), 64'd0);
    chk("stall_valid", 64'(resp_valid_o), 64'd1);
    rst_i = 1; req_valid_i = 0;
    @(posedge clk_i); #1;
    rst_i = 0;
    chk("rst_drop", 64'(resp_valid_o), 64'd0);
    rdy_mode = 0;

    // Randomized traffic with backpressure and one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) rdy_mode = $urandom % 2;
      if (i == 200) begin
        @(posedge clk_i); #1; rst_i = 1;
        @(posedge clk_i); #1; rst_i = 0;
      end
      case ($urandom % 6)
        0: a = 12'h000;
        1: a = 12'h008;
        2: a = 12'h010;
        3: a = 12'h018;
        4: a = 12'h004;
        default: a = 12'($urandom);
      endcase
      d = {$urandom, $urandom};
      if (a == 12'h010) d[23:8] = 16'($urandom % 4);
      if ($urandom % 4 == 0) repeat ($urandom % 4) @(posedge clk_i);
      do_req($urandom % 2 == 1, a, d, 8'($urandom));
    end
    rdy_mode = 0;
    drain();
    repeat (3) @(posedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
